key_entry_buffer: RTL

- Sits directly downstream of the 4x4 keypad scanner and consumes its 4-bit key code and level-type key-valid flag.
- Turns each distinct key press into a single event and assembles successive hex digits into a multi-digit entry for the LCD and control logic.
- Supports clear, delete-last and enter keys, plus an inactivity timeout.
- Commits the completed value with a one-cycle strobe.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/key_press_detect.sv | 63 ++++++
 rtl/key_entry_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: control key codes, press-detect FSM states
// and a helper that classifies a key code as a digit or a control key.
package keypad_pkg;

    localparam logic [3:0] KEY_CLR = 4'hC;
    localparam logic [3:0] KEY_DEL = 4'hD;
    localparam logic [3:0] KEY_ENT = 4'hE;

    typedef enum logic {
        S_WAIT_PRESS   = 1'b0,
        S_WAIT_RELEASE = 1'b1
    } press_state_e;

    typedef enum logic [1:0] {
        K_DIGIT,
        K_CLR,
        K_DEL,
        K_ENT
    } key_kind_e;

    function automatic key_kind_e classify_key(
        input logic [3:0] code,
        input logic [3:0] clr,
        input logic [3:0] del,
        input logic [3:0] ent
    );
        key_kind_e kind;
        kind = K_DIGIT;
        if (code == clr)
            kind = K_CLR;
        else if (code == del)
            kind = K_DEL;
        else if (code == ent)
            kind = K_ENT;
        return kind;
    endfunction

endpackage

// File: rtl/key_press_detect.sv
// Synchronises the scanner key-held flag and emits one press event per press.
// Ports: i_clk, i_rst_n, i_key_val/i_key_valid in; o_press_evt, o_key_code out.
module key_press_detect
    import keypad_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_key_val,
    input  logic       i_key_valid,
    output logic       o_press_evt,
    output logic [3:0] o_key_code
);

    logic [1:0]   sync_r;
    logic         kv_s;
    press_state_e state_r;
    press_state_e state_nxt;
    logic         press_nxt;

    assign kv_s = sync_r[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], i_key_valid};
        end
    end

    always_comb begin
        state_nxt = state_r;
        press_nxt = 1'b0;
        unique case (state_r)
            S_WAIT_PRESS: begin
                if (kv_s) begin
                    state_nxt = S_WAIT_RELEASE;
                    press_nxt = 1'b1;
                end
            end
            S_WAIT_RELEASE: begin
                if (!kv_s)
                    state_nxt = S_WAIT_PRESS;
            end
            default: state_nxt = S_WAIT_PRESS;
        endcase
    end

    // Key code is captured together with the event so decoding sees a
    // value that was stable while the flag was high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= S_WAIT_PRESS;
            o_press_evt <= 1'b0;
            o_key_code  <= 4'h0;
        end else begin
            state_r     <= state_nxt;
            o_press_evt <= press_nxt;
            if (press_nxt)
                o_key_code <= i_key_val;
        end
    end

endmodule

// File: rtl/key_entry_buffer.sv
// Assembles keypad presses into a multi-digit hex entry with clear/delete/
// enter keys and inactivity auto-clear. Ports: i_clk, i_rst_n, i_key_val,
// i_key_valid in; o_entry, o_digit_cnt, o_value, o_value_cnt,
// o_value_valid (commit pulse), o_overflow (sticky), o_timeout (pulse) out.
module key_entry_buffer
    import keypad_pkg::*;
#(
    parameter int unsigned MAX_DIGITS  = 4,
    parameter logic [3:0]  CLR_KEY     = KEY_CLR,
    parameter logic [3:0]  DEL_KEY     = KEY_DEL,
    parameter logic [3:0]  ENT_KEY     = KEY_ENT,
    parameter logic [31:0] TIMEOUT_CYC = 32'd250_000_000
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [3:0]                         i_key_val,
    input  logic                               i_key_valid,
    output logic [4*MAX_DIGITS-1:0]            o_entry,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    o_digit_cnt,
    output logic [4*MAX_DIGITS-1:0]            o_value,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    o_value_cnt,
    output logic                               o_value_valid,
    output logic                               o_overflow,
    output logic                               o_timeout
);

    localparam int EW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic        press_evt;
    logic [3:0]  key_code;
    key_kind_e   kind;
    logic [31:0] tmo_cnt;
    logic        tmo_en;
    logic        tmo_hit;

    key_press_detect u_detect (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_key_val   (i_key_val),
        .i_key_valid (i_key_valid),
        .o_press_evt (press_evt),
        .o_key_code  (key_code)
    );

    assign kind    = classify_key(key_code, CLR_KEY, DEL_KEY, ENT_KEY);
    assign tmo_en  = (TIMEOUT_CYC != 32'd0) && (o_digit_cnt != '0);
    assign tmo_hit = tmo_en && (tmo_cnt == TIMEOUT_CYC - 32'd1);

    // A press event takes priority over expiry in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_entry       <= '0;
            o_digit_cnt   <= '0;
            o_value       <= '0;
            o_value_cnt   <= '0;
            o_value_valid <= 1'b0;
            o_overflow    <= 1'b0;
            o_timeout     <= 1'b0;
            tmo_cnt       <= 32'd0;
        end else begin
            o_value_valid <= 1'b0;
            o_timeout     <= 1'b0;
            if (press_evt) begin
                tmo_cnt <= 32'd0;
                unique case (kind)
                    K_DIGIT: begin
                        if (o_digit_cnt < CW'(MAX_DIGITS)) begin
                            o_entry     <= (o_entry << 4) | EW'(key_code);
                            o_digit_cnt <= o_digit_cnt + CW'(1);
                        end else begin
                            o_overflow  <= 1'b1;
                        end
                    end
                    K_CLR: begin
                        o_entry     <= '0;
                        o_digit_cnt <= '0;
                        o_overflow  <= 1'b0;
                    end
                    K_DEL: begin
                        if (o_digit_cnt != '0) begin
                            o_entry     <= o_entry >> 4;
                            o_digit_cnt <= o_digit_cnt - CW'(1);
                        end
                    end
                    K_ENT: begin
                        if (o_digit_cnt != '0) begin
                            o_value       <= o_entry;
                            o_value_cnt   <= o_digit_cnt;
                            o_value_valid <= 1'b1;
                            o_entry       <= '0;
                            o_digit_cnt   <= '0;
                            o_overflow    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (tmo_hit) begin
                o_entry     <= '0;
                o_digit_cnt <= '0;
                o_overflow  <= 1'b0;
                o_timeout   <= 1'b1;
                tmo_cnt     <= 32'd0;
            end else if (tmo_en) begin
                tmo_cnt <= tmo_cnt + 32'd1;
            end else begin
                tmo_cnt <= 32'd0;
            end
        end
    end

endmodule
